gppcu_issue_ctrl: RTL and testbench

- Per-lane instruction sequencer for the GPPCU.
- Fetches 32-bit instructions from instruction memory, presents the opcode to the combinational instruction decoder, and consumes the returned control word.
- Issues single-cycle ALU/memory ops directly; launches multi-cycle FPU ops and waits on a done handshake with a watchdog.
- Gates register write-back, and reports busy/done/error plus a cycle count to the host.

---
 rtl/gppcu_issue_ctrl_pkg.sv | 46 ++++
 rtl/gppcu_watchdog.sv | 29 ++
 rtl/gppcu_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_gppcu_issue_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppcu_issue_ctrl_pkg.sv
// Shared definitions for the GPPCU per-lane issue controller: control-word
// bit map, sequencer states and small helpers.
package gppcu_issue_ctrl_pkg;

    localparam int CW_BITS = 19;

    localparam int CW_REGWR    = 1;
    localparam int CW_GMEMRD   = 2;
    localparam int CW_BSEL_LO  = 3;
    localparam int CW_BSEL_HI  = 4;
    localparam int CW_ALOPC_LO = 5;
    localparam int CW_ALOPC_HI = 8;
    localparam int CW_FPOPC_LO = 9;
    localparam int CW_FPOPC_HI = 12;
    localparam int CW_LMEMWR   = 13;
    localparam int CW_LMEMRD   = 14;
    localparam int CW_FPOP     = 15;
    localparam int CW_ALOP     = 16;
    localparam int CW_USEREGB  = 17;
    localparam int CW_USEREGA  = 18;

    localparam int OPC_BITS = 5;
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;

    typedef logic [CW_BITS-1:1] ctrlWord_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LATCH    = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_FPU = 3'd4,
        ST_DONE     = 3'd5
    } issueState_e;

    // Only FPU ops that write a register go through the multi-cycle path.
    function automatic logic isFpuLaunch(input ctrlWord_t cw);
        return cw[CW_FPOP] & cw[CW_REGWR];
    endfunction

    function automatic logic isBusyState(input issueState_e s);
        return (s == ST_FETCH) || (s == ST_LATCH) || (s == ST_EXEC) || (s == ST_WAIT_FPU);
    endfunction

endpackage

// File: rtl/gppcu_watchdog.sv
// Loadable saturating up-counter; terminal is high once the count reaches LIMIT-1.
module gppcu_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic resetN,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_BITS = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LIMIT - 1);

    logic [CNT_BITS-1:0] count;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/gppcu_issue_ctrl.sv
// Per-lane instruction sequencer: fetch, latch, execute, optional FPU wait
// with watchdog, write-back gating and busy-cycle accounting.
module gppcu_issue_ctrl
    import gppcu_issue_ctrl_pkg::*;
#(
    parameter int PC_BITS     = 10,
    parameter int FPU_TIMEOUT = 64,
    parameter int CYC_BITS    = 24
) (
    input  logic                iCLK,
    input  logic                iRSTn,
    input  logic                iSTART,
    input  logic                iABORT,
    input  logic [PC_BITS:0]    iPROG_LEN,
    output logic [PC_BITS-1:0]  oIMEM_ADDR,
    output logic                oIMEM_RD,
    input  logic [31:0]         iIMEM_DATA,
    output logic [OPC_BITS-1:0] oOPC,
    input  logic [CW_BITS-1:1]  iCW,
    output logic                oFPU_START,
    input  logic                iFPU_DONE,
    output logic                oREG_WE,
    output logic                oISSUE,
    output logic                oBUSY,
    output logic                oDONE,
    output logic                oERR,
    output logic [CYC_BITS-1:0] oCYCLES
);

    issueState_e         state;
    issueState_e         stateNext;

    // One bit wider than the address so runs longer than memory wrap the PC.
    logic [PC_BITS:0]    instrCount;
    logic [PC_BITS:0]    instrCountNext;
    logic                lastInstr;

    logic [OPC_BITS-1:0] opcReg;
    logic [CYC_BITS-1:0] cycles;
    logic                errFlag;

    logic                imemRd;
    logic                fpuStart;
    logic                regWe;
    logic                issue;
    logic                advance;
    logic                startRun;
    logic                timeout;
    logic                wdLoad;
    logic                wdEnable;
    logic                wdTerminal;
    logic                unusedBits;

    assign instrCountNext = instrCount + 1'b1;
    assign lastInstr      = (instrCountNext == iPROG_LEN);

    gppcu_watchdog #(
        .LIMIT    (FPU_TIMEOUT)
    ) uWatchdog (
        .clock    (iCLK),
        .resetN   (iRSTn),
        .load     (wdLoad),
        .enable   (wdEnable),
        .terminal (wdTerminal)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        imemRd    = 1'b0;
        fpuStart  = 1'b0;
        regWe     = 1'b0;
        issue     = 1'b0;
        advance   = 1'b0;
        startRun  = 1'b0;
        timeout   = 1'b0;
        wdLoad    = 1'b0;
        wdEnable  = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (iSTART) begin
                    startRun  = 1'b1;
                    stateNext = (iPROG_LEN == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                imemRd    = 1'b1;
                stateNext = ST_LATCH;
            end
            ST_LATCH: begin
                stateNext = ST_EXEC;
            end
            ST_EXEC: begin
                if (isFpuLaunch(iCW)) begin
                    fpuStart  = 1'b1;
                    wdLoad    = 1'b1;
                    stateNext = ST_WAIT_FPU;
                end else begin
                    issue     = 1'b1;
                    regWe     = iCW[CW_REGWR];
                    advance   = 1'b1;
                    stateNext = lastInstr ? ST_DONE : ST_FETCH;
                end
            end
            ST_WAIT_FPU: begin
                wdEnable = 1'b1;
                // A result arriving in the final watchdog cycle still counts.
                if (iFPU_DONE) begin
                    issue     = 1'b1;
                    regWe     = 1'b1;
                    advance   = 1'b1;
                    stateNext = lastInstr ? ST_DONE : ST_FETCH;
                end else if (wdTerminal) begin
                    timeout   = 1'b1;
                    stateNext = ST_DONE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        if (iABORT) begin
            stateNext = ST_IDLE;
            imemRd    = 1'b0;
            fpuStart  = 1'b0;
            regWe     = 1'b0;
            issue     = 1'b0;
            advance   = 1'b0;
            startRun  = 1'b0;
            timeout   = 1'b0;
            wdLoad    = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            instrCount <= '0;
            opcReg     <= '0;
            cycles     <= '0;
            errFlag    <= 1'b0;
        end else begin
            if (startRun) begin
                instrCount <= '0;
                cycles     <= '0;
                errFlag    <= 1'b0;
            end else begin
                if (advance) begin
                    instrCount <= instrCountNext;
                end
                if (isBusyState(state) && !iABORT && (cycles != '1)) begin
                    cycles <= cycles + 1'b1;
                end
                if (timeout) begin
                    errFlag <= 1'b1;
                end
            end
            if ((state == ST_LATCH) && !iABORT) begin
                opcReg <= iIMEM_DATA[OPC_MSB:OPC_LSB];
            end
        end
    end

    assign unusedBits = ^{iIMEM_DATA[OPC_LSB-1:0], iCW[CW_BITS-1:CW_FPOP+1], iCW[CW_FPOP-1:CW_REGWR+1]};

    assign oIMEM_ADDR = instrCount[PC_BITS-1:0];
    assign oIMEM_RD   = imemRd;
    assign oOPC       = opcReg;
    assign oFPU_START = fpuStart;
    assign oREG_WE    = regWe;
    assign oISSUE     = issue;
    assign oBUSY      = isBusyState(state);
    assign oDONE      = (state == ST_DONE);
    assign oERR       = errFlag;
    assign oCYCLES    = cycles;

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// Self-checking bench for gppcu_issue_ctrl: directed vector table, hand-written
// abort/reset sequences and randomized programs against a per-instruction cost model.
module tb_gppcu_issue_ctrl;

    localparam int PC_BITS     = 10;
    localparam int FPU_TIMEOUT = 64;
    localparam int CYC_BITS    = 24;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_MOV  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_FADD = 5'd8;
    localparam logic [4:0] OP_FDIV = 5'd9;
    localparam logic [4:0] OP_FNEG = 5'd10;

    logic                iCLK;
    logic                iRSTn;
    logic                iSTART;
    logic                iABORT;
    logic [PC_BITS:0]    iPROG_LEN;
    logic [PC_BITS-1:0]  oIMEM_ADDR;
    logic                oIMEM_RD;
    logic [31:0]         iIMEM_DATA;
    logic [4:0]          oOPC;
    logic [18:1]         iCW;
    logic                oFPU_START;
    logic                iFPU_DONE;
    logic                oREG_WE;
    logic                oISSUE;
    logic                oBUSY;
    logic                oDONE;
    logic                oERR;
    logic [CYC_BITS-1:0] oCYCLES;

    gppcu_issue_ctrl #(
        .PC_BITS     (PC_BITS),
        .FPU_TIMEOUT (FPU_TIMEOUT),
        .CYC_BITS    (CYC_BITS)
    ) dut (
        .iCLK       (iCLK),
        .iRSTn      (iRSTn),
        .iSTART     (iSTART),
        .iABORT     (iABORT),
        .iPROG_LEN  (iPROG_LEN),
        .oIMEM_ADDR (oIMEM_ADDR),
        .oIMEM_RD   (oIMEM_RD),
        .iIMEM_DATA (iIMEM_DATA),
        .oOPC       (oOPC),
        .iCW        (iCW),
        .oFPU_START (oFPU_START),
        .iFPU_DONE  (iFPU_DONE),
        .oREG_WE    (oREG_WE),
        .oISSUE     (oISSUE),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oERR       (oERR),
        .oCYCLES    (oCYCLES)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic [31:0] mem [1024];
    logic [18:1] cwTable [32];
    int          latByLaunch [16];

    assign iCW = cwTable[oOPC];

    int seenRegWe, seenFpuStart, seenIssue, seenReads, addrErrors;
    int launchCount, fpuCount;
    bit fpuWaiting, strayDone;
    int testsRun, failCount;

    typedef struct {
        int busy; int regWe; int fpu; int issue; int reads; bit err;
    } expectT;

    typedef struct {
        int progLen; logic [19:0] ops; int lat0; int lat1;
        int expBusy; int expRegWe; int expFpu; int expIssue; int expReads; bit expErr;
    } vecT;

    vecT vecs [10];

    // Memory, FPU and strobe monitor: drive at the falling edge, sample 1ns later.
    always @(negedge iCLK) begin
        iFPU_DONE = 1'b0;
        if (fpuCount > 0) begin
            fpuCount--;
            if (fpuCount == 0) begin
                iFPU_DONE  = 1'b1;
                fpuWaiting = 1'b0;
            end
        end else if (strayDone && !fpuWaiting && ($urandom_range(0, 3) == 0)) begin
            iFPU_DONE = 1'b1;
        end
        if (oIMEM_RD) iIMEM_DATA = mem[oIMEM_ADDR];
        #1;
        if (oIMEM_RD) begin
            if (int'(oIMEM_ADDR) != (seenReads % 1024)) addrErrors++;
            seenReads++;
        end
        if (oFPU_START) begin
            seenFpuStart++;
            fpuWaiting = 1'b1;
            fpuCount   = latByLaunch[launchCount % 16];
            launchCount++;
        end
        if (oREG_WE) seenRegWe++;
        if (oISSUE) seenIssue++;
    end

    function automatic logic [18:1] mkCw(input bit regWr, input bit fpOp, input logic [3:0] fpOpc, input bit alOp);
        logic [18:1] cw;
        cw = '0;
        cw[1]     = regWr;
        cw[15]    = fpOp;
        cw[12:9]  = fpOpc;
        cw[16]    = alOp;
        return cw;
    endfunction

    // Cost per instruction: 3 cycles, plus the FPU wait (capped at the watchdog limit).
    function automatic expectT modelRun(input int progLen);
        expectT e;
        logic [18:1] cw;
        int lat;
        e = '{0, 0, 0, 0, 0, 1'b0};
        for (int i = 0; i < progLen; i++) begin
            cw = cwTable[mem[i % 1024][31:27]];
            e.reads++;
            if (cw[15] && cw[1]) begin
                lat = latByLaunch[e.fpu % 16];
                e.fpu++;
                if (lat >= 1 && lat <= FPU_TIMEOUT) begin
                    e.busy += 3 + lat;
                    e.regWe++;
                    e.issue++;
                end else begin
                    e.busy += 3 + FPU_TIMEOUT;
                    e.err = 1'b1;
                    break;
                end
            end else begin
                e.busy += 3;
                e.issue++;
                if (cw[1]) e.regWe++;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetCounters();
        seenRegWe = 0; seenFpuStart = 0; seenIssue = 0; seenReads = 0; addrErrors = 0;
        launchCount = 0; fpuCount = 0; fpuWaiting = 1'b0;
    endtask

    task automatic applyStimulus(input int progLen, input bit randomStarts, output int latency, output bit timedOut);
        @(negedge iCLK);
        iPROG_LEN = (PC_BITS+1)'(progLen);
        iSTART    = 1'b1;
        resetCounters();
        latency  = -1;
        timedOut = 1'b1;
        for (int j = 1; j <= 5000; j++) begin
            @(negedge iCLK);
            iSTART = 1'b0;
            if (randomStarts && oBUSY && ($urandom_range(0, 7) == 0)) iSTART = 1'b1;
            #1;
            if (oDONE) begin
                latency  = j - 1;
                timedOut = 1'b0;
                break;
            end
        end
        iSTART = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input int progLen, input expectT e, input bit randomStarts);
        int latency;
        bit timedOut;
        applyStimulus(progLen, randomStarts, latency, timedOut);
        checkOutput({tag, " doneReached"}, 64'(timedOut), 64'd0);
        checkOutput({tag, " latency"},     64'(latency), 64'(e.busy));
        checkOutput({tag, " cycles"},      64'(oCYCLES), 64'(e.busy));
        checkOutput({tag, " err"},         64'(oERR), 64'(e.err));
        checkOutput({tag, " regWe"},       64'(seenRegWe), 64'(e.regWe));
        checkOutput({tag, " fpuStart"},    64'(seenFpuStart), 64'(e.fpu));
        checkOutput({tag, " issue"},       64'(seenIssue), 64'(e.issue));
        checkOutput({tag, " reads"},       64'(seenReads), 64'(e.reads));
        checkOutput({tag, " addr"},        64'(addrErrors), 64'd0);
    endtask

    initial begin
        expectT e;
        logic [19:0] opTmp;
        bit found;
        int pick;
        int len;

        testsRun = 0; failCount = 0; strayDone = 1'b0;
        iRSTn = 1'b0; iSTART = 1'b0; iABORT = 1'b0; iPROG_LEN = '0;
        iIMEM_DATA = '0; iFPU_DONE = 1'b0;
        resetCounters();
        for (int i = 0; i < 16; i++) latByLaunch[i] = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 32; i++) cwTable[i] = 18'($urandom);
        cwTable[OP_NOP]  = '0;
        cwTable[OP_MOV]  = mkCw(1'b1, 1'b0, 4'd0, 1'b0);
        cwTable[OP_ADC]  = mkCw(1'b1, 1'b0, 4'd0, 1'b1) | 18'h30000;
        cwTable[OP_FADD] = mkCw(1'b1, 1'b1, 4'd1, 1'b0);
        cwTable[OP_FDIV] = mkCw(1'b1, 1'b1, 4'd4, 1'b0);
        cwTable[OP_FNEG] = mkCw(1'b0, 1'b1, 4'd6, 1'b0);

        vecs[0] = '{3, {OP_NOP, OP_NOP, OP_ADC, OP_MOV},   0, 0,  9, 2, 0, 3, 3, 1'b0};
        vecs[1] = '{0, {OP_MOV, OP_MOV, OP_MOV, OP_MOV},   0, 0,  0, 0, 0, 0, 0, 1'b0};
        vecs[2] = '{1, {OP_NOP, OP_NOP, OP_NOP, OP_FADD},  5, 0,  8, 1, 1, 1, 1, 1'b0};
        vecs[3] = '{1, {OP_NOP, OP_NOP, OP_NOP, OP_FDIV},  0, 0, 67, 0, 1, 0, 1, 1'b1};
        vecs[4] = '{1, {OP_NOP, OP_NOP, OP_NOP, OP_FNEG},  0, 0,  3, 0, 0, 1, 1, 1'b0};
        vecs[5] = '{1, {OP_NOP, OP_NOP, OP_NOP, OP_FADD}, 64, 0, 67, 1, 1, 1, 1, 1'b0};
        vecs[6] = '{1, {OP_NOP, OP_NOP, OP_NOP, OP_FADD}, 65, 0, 67, 0, 1, 0, 1, 1'b1};
        vecs[7] = '{3, {OP_NOP, OP_MOV, OP_FADD, OP_ADC},  2, 0, 11, 3, 1, 3, 3, 1'b0};
        vecs[8] = '{2, {OP_NOP, OP_NOP, OP_MOV, OP_FDIV},  0, 0, 67, 0, 1, 0, 1, 1'b1};
        vecs[9] = '{4, {OP_NOP, OP_MOV, OP_FADD, OP_FADD}, 1, 3, 16, 3, 2, 4, 4, 1'b0};

        // Reset state
        #3;
        checkOutput("resetAll", 64'({oIMEM_ADDR, oIMEM_RD, oOPC, oFPU_START, oREG_WE, oISSUE,
                                     oBUSY, oDONE, oERR, oCYCLES}), 64'd0);
        repeat (2) @(negedge iCLK);
        checkOutput("resetHeldIdle", 64'({oBUSY, oDONE, oERR}), 64'd0);
        iRSTn = 1'b1;

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            for (int a = 0; a < 1024; a++) mem[a] = '0;
            opTmp = vecs[v].ops;
            for (int k = 0; k < 4; k++) mem[k] = {opTmp[k*5 +: 5], 27'd0};
            for (int i = 0; i < 16; i++) latByLaunch[i] = 0;
            latByLaunch[0] = vecs[v].lat0;
            latByLaunch[1] = vecs[v].lat1;
            e = '{vecs[v].expBusy, vecs[v].expRegWe, vecs[v].expFpu, vecs[v].expIssue,
                  vecs[v].expReads, vecs[v].expErr};
            runAndCheck($sformatf("vec%0d", v), vecs[v].progLen, e, 1'b0);
        end

        // Timeout sets the error, next start clears it, then abort during the FPU wait
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        mem[0] = {OP_FDIV, 27'd0};
        for (int i = 0; i < 16; i++) latByLaunch[i] = 0;
        runAndCheck("fdivTimeout", 1, '{67, 0, 1, 0, 1, 1'b1}, 1'b0);
        checkOutput("errSticky", 64'(oERR), 64'd1);
        @(negedge iCLK);
        iPROG_LEN = 11'd1;
        iSTART    = 1'b1;
        resetCounters();
        @(negedge iCLK);
        iSTART = 1'b0;
        #1;
        checkOutput("errClearedOnStart", 64'(oERR), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (oFPU_START) found = 1'b1;
            else begin
                @(negedge iCLK);
                #1;
            end
        end
        checkOutput("abortLaunchSeen", 64'(found), 64'd1);
        repeat (3) @(negedge iCLK);
        iABORT = 1'b1;
        @(negedge iCLK);
        iABORT = 1'b0;
        #1;
        checkOutput("abortIdle", 64'({oBUSY, oDONE}), 64'd0);
        checkOutput("abortCyclesHeld", 64'(oCYCLES), 64'd5);
        checkOutput("abortErr", 64'(oERR), 64'd0);
        fpuWaiting = 1'b1;
        fpuCount   = 2;
        repeat (4) @(negedge iCLK);
        #1;
        checkOutput("lateDoneNoWrite", 64'(seenRegWe), 64'd0);
        checkOutput("lateDoneNoIssue", 64'(seenIssue), 64'd0);
        checkOutput("abortOneLaunch", 64'(seenFpuStart), 64'd1);
        checkOutput("lateDoneStillIdle", 64'({oBUSY, oDONE}), 64'd0);

        // Asynchronous reset in the middle of the second fetch
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        mem[0] = {OP_MOV, 27'd0};
        mem[1] = {OP_ADC, 27'd0};
        @(negedge iCLK);
        iPROG_LEN = 11'd3;
        iSTART    = 1'b1;
        resetCounters();
        @(negedge iCLK);
        iSTART = 1'b0;
        #1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (oIMEM_RD && oIMEM_ADDR == 10'd1) found = 1'b1;
            else begin
                @(negedge iCLK);
                #1;
            end
        end
        checkOutput("midFetchSeen", 64'(found), 64'd1);
        checkOutput("midFetchOpc", 64'(oOPC), 64'(OP_MOV));
        iRSTn = 1'b0;
        #1;
        checkOutput("asyncResetAll", 64'({oIMEM_ADDR, oIMEM_RD, oOPC, oFPU_START, oREG_WE, oISSUE,
                                          oBUSY, oDONE, oERR, oCYCLES}), 64'd0);
        @(negedge iCLK);
        iRSTn = 1'b1;

        // Randomized programs with stray done pulses and ignored mid-run starts
        strayDone = 1'b1;
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < 8; a++) mem[a] = {5'($urandom_range(0, 31)), 27'($urandom)};
            for (int i = 0; i < 16; i++) begin
                pick = $urandom_range(0, 19);
                if (pick == 0)      latByLaunch[i] = 0;
                else if (pick == 1) latByLaunch[i] = FPU_TIMEOUT;
                else if (pick == 2) latByLaunch[i] = FPU_TIMEOUT + 1;
                else                latByLaunch[i] = $urandom_range(1, 8);
            end
            len = $urandom_range(1, 8);
            e = modelRun(len);
            runAndCheck($sformatf("rand%0d", r), len, e, 1'b1);
        end
        strayDone = 1'b0;

        // Program longer than instruction memory wraps to address 0
        for (int a = 0; a < 1024; a++) mem[a] = {((a % 3) == 0) ? OP_MOV : OP_NOP, 27'd0};
        e = modelRun(1030);
        runAndCheck("pcWrap", 1030, e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
